// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR recovery controller.
// Optional fault statistics are enabled with TMR_FAULT_CNT_EN.
package tmr_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned VS_W   = 3;
    localparam int unsigned FCNT_W = 8;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_RESYNC   = 2'd1,
        ST_ROLLBACK = 2'd2,
        ST_FATAL    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_A    = 2'd1,
        FC_B    = 2'd2,
        FC_C    = 2'd3
    } fault_core_e;

    // Agreement vector is {AB, BC, AC}; a single bad core leaves only the other pair agreeing.
    localparam logic [VS_W-1:0] VS_OK    = 3'b111;
    localparam logic [VS_W-1:0] VS_A_BAD = 3'b010;
    localparam logic [VS_W-1:0] VS_B_BAD = 3'b001;
    localparam logic [VS_W-1:0] VS_C_BAD = 3'b100;

    function automatic fault_core_e vs_bad_core(input logic [VS_W-1:0] vs);
        fault_core_e fc;
        case (vs)
            VS_A_BAD: fc = FC_A;
            VS_B_BAD: fc = FC_B;
            VS_C_BAD: fc = FC_C;
            default:  fc = FC_NONE;
        endcase
        return fc;
    endfunction

endpackage

// File: rtl/tmr_ckpt_stack.sv
// Circular checkpoint stack: push overwrites the oldest entry when full,
// pop on empty is ignored, top is the most recently pushed live entry.
module tmr_ckpt_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic [W-1:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_BITS-1:0] cnt_q;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_BITS'(DEPTH));
    assign top_o   = mem_q[wr_ptr_q - PTR_W'(1)];

    // Write pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CNT_BITS'(1);
            end
        end else if (pop_i && !empty_o) begin
            wr_ptr_q <= wr_ptr_q - PTR_W'(1);
            cnt_q    <= cnt_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery controller: resyncs a single faulty core or rolls all cores back to a checkpoint.
// Define TMR_FAULT_CNT_EN to add per-core fault and rollback event counters.
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int unsigned     CKPT_DEPTH      = 8,
    parameter int unsigned     RESYNC_CYCLES   = 4,
    parameter int unsigned     ROLLBACK_CYCLES = 6,
    parameter int unsigned     MAX_RETRY       = 3,
    parameter logic [PC_W-1:0] RESET_PC        = 32'h0
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [VS_W-1:0]   Voter_state,
    input  logic              core_hold,
    input  logic [PC_W-1:0]   PC_Top,
    output logic              resync_A,
    output logic              resync_B,
    output logic              resync_C,
    output logic [PC_W-1:0]   PC_resync,
    output logic              rollback,
    output logic [PC_W-1:0]   PC_rollback,
    output logic              core_stall,
    output logic [1:0]        fault_core,
    output logic              fatal
`ifdef TMR_FAULT_CNT_EN
    ,
    output logic [FCNT_W-1:0] fault_cnt_A,
    output logic [FCNT_W-1:0] fault_cnt_B,
    output logic [FCNT_W-1:0] fault_cnt_C,
    output logic [FCNT_W-1:0] rollback_cnt
`endif
);

    localparam int unsigned TMR_MAX = (RESYNC_CYCLES > ROLLBACK_CYCLES) ? RESYNC_CYCLES : ROLLBACK_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    fault_core_e         fc_q, fc_d;
    logic [PC_W-1:0]     pc_resync_q, pc_resync_d;
    logic [PC_W-1:0]     pc_rb_q, pc_rb_d;
    logic                resync_a_q, resync_b_q, resync_c_q;
    logic                rollback_q, stall_q, fatal_q;

    logic                stk_push, stk_pop, stk_empty, stk_unused_full;
    logic [PC_W-1:0]     stk_top;

    fault_core_e         bad_core;
    logic                is_ok, is_single, is_ambig, enter_rb;

    tmr_ckpt_stack #(
        .DEPTH (CKPT_DEPTH),
        .W     (PC_W)
    ) u_ckpt_stack (
        .clk     (clk),
        .rst_in  (rst_in),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (PC_Top),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_unused_full)
    );

    // core_hold overrides any agreement pattern and is treated as total disagreement.
    always_comb begin
        bad_core  = vs_bad_core(Voter_state);
        is_ok     = !core_hold && (Voter_state == VS_OK);
        is_single = !core_hold && (bad_core != FC_NONE);
        is_ambig  = !is_ok && !is_single;
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        retry_d     = retry_q;
        fc_d        = fc_q;
        pc_resync_d = pc_resync_q;
        pc_rb_d     = pc_rb_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        enter_rb    = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (is_ok) begin
                    retry_d  = '0;
                    stk_push = stk_empty || (PC_Top != stk_top);
                end else if (is_single) begin
                    state_d     = ST_RESYNC;
                    tmr_d       = TMR_W'(RESYNC_CYCLES - 1);
                    pc_resync_d = PC_Top;
                    fc_d        = bad_core;
                end else begin
                    enter_rb = 1'b1;
                end
            end
            ST_RESYNC: begin
                if (is_ambig) begin
                    enter_rb = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = ST_NORMAL;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_ROLLBACK: begin
                if (tmr_q == '0) begin
                    state_d = ST_NORMAL;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_FATAL;
            end
        endcase

        // Each consecutive rollback consumes one checkpoint until the retry budget runs out.
        if (enter_rb) begin
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
                state_d = ST_FATAL;
            end else begin
                state_d = ST_ROLLBACK;
                tmr_d   = TMR_W'(ROLLBACK_CYCLES - 1);
                retry_d = retry_q + RETRY_W'(1);
                pc_rb_d = stk_empty ? RESET_PC : stk_top;
                stk_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= ST_NORMAL;
            tmr_q       <= '0;
            retry_q     <= '0;
            fc_q        <= FC_NONE;
            pc_resync_q <= '0;
            pc_rb_q     <= RESET_PC;
            resync_a_q  <= 1'b0;
            resync_b_q  <= 1'b0;
            resync_c_q  <= 1'b0;
            rollback_q  <= 1'b0;
            stall_q     <= 1'b0;
            fatal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            fc_q        <= fc_d;
            pc_resync_q <= pc_resync_d;
            pc_rb_q     <= pc_rb_d;
            resync_a_q  <= (state_d == ST_RESYNC) && (fc_d == FC_A);
            resync_b_q  <= (state_d == ST_RESYNC) && (fc_d == FC_B);
            resync_c_q  <= (state_d == ST_RESYNC) && (fc_d == FC_C);
            rollback_q  <= (state_d == ST_ROLLBACK);
            stall_q     <= (state_d != ST_NORMAL);
            fatal_q     <= (state_d == ST_FATAL);
        end
    end

    assign resync_A    = resync_a_q;
    assign resync_B    = resync_b_q;
    assign resync_C    = resync_c_q;
    assign PC_resync   = pc_resync_q;
    assign rollback    = rollback_q;
    assign PC_rollback = pc_rb_q;
    assign core_stall  = stall_q;
    assign fault_core  = fc_q;
    assign fatal       = fatal_q;

`ifdef TMR_FAULT_CNT_EN
    logic [FCNT_W-1:0] fcnt_a_q, fcnt_b_q, fcnt_c_q, rb_cnt_q;

    // Saturating event counters; only a fresh entry into RESYNC/ROLLBACK counts.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            fcnt_a_q <= '0;
            fcnt_b_q <= '0;
            fcnt_c_q <= '0;
            rb_cnt_q <= '0;
        end else begin
            if ((state_q == ST_NORMAL) && (state_d == ST_RESYNC)) begin
                case (fc_d)
                    FC_A:    if (fcnt_a_q != '1) fcnt_a_q <= fcnt_a_q + FCNT_W'(1);
                    FC_B:    if (fcnt_b_q != '1) fcnt_b_q <= fcnt_b_q + FCNT_W'(1);
                    FC_C:    if (fcnt_c_q != '1) fcnt_c_q <= fcnt_c_q + FCNT_W'(1);
                    default: ;
                endcase
            end
            if ((state_d == ST_ROLLBACK) && (state_q != ST_ROLLBACK) && (rb_cnt_q != '1)) begin
                rb_cnt_q <= rb_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign fault_cnt_A  = fcnt_a_q;
    assign fault_cnt_B  = fcnt_b_q;
    assign fault_cnt_C  = fcnt_c_q;
    assign rollback_cnt = rb_cnt_q;
`endif

endmodule
